// File: rtl/encode8to3_stream.sv
`default_nettype none
// ============================================================================
// Module   : encode8to3_stream
// Brief    : Sequential 8-to-3 priority encoder. Accepts a multi-hot vector
//            over valid/ready and emits one binary index per set bit, in
//            priority order, over a second valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module encode8to3_stream #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_code,
    output logic       out_last,
    output logic [2:0] out_seq,
    output logic       zero_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_next;
    logic [7:0] r_pend;
    logic [2:0] r_seq;
    logic       r_zero_err;
    logic [2:0] w_code;
    logic       w_single;
    logic       w_accept;
    logic       w_fire;
    logic [7:0] w_mask;

    // Priority pick of the next index to emit; direction fixed at elaboration.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            // Lowest set bit wins: scan downwards so the last hit is the lowest.
            always_comb begin
                w_code = 3'd0;
                for (int i = 7; i >= 0; i--) begin
                    if (r_pend[i]) w_code = 3'(i);
                end
            end
        end else begin : g_msb_first
            // Highest set bit wins: scan upwards so the last hit is the highest.
            always_comb begin
                w_code = 3'd0;
                for (int i = 0; i < 8; i++) begin
                    if (r_pend[i]) w_code = 3'(i);
                end
            end
        end
    endgenerate

    // Exactly one pending bit means the current index closes the vector.
    assign w_single = (r_pend != 8'h00) && ((r_pend & (r_pend - 8'd1)) == 8'h00);
    assign w_mask   = 8'(8'h01 << w_code);

    // State register; reset discards any in-flight vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_fire    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && (in_vec != 8'h00)) w_next = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                w_fire    = out_ready;
                if (out_ready && w_single) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Pending bits, ordinal counter and the zero-vector pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 8'h00;
            r_seq      <= 3'd0;
            r_zero_err <= 1'b0;
        end else begin
            r_zero_err <= w_accept && (in_vec == 8'h00);
            if (w_accept && (in_vec != 8'h00)) begin
                r_pend <= in_vec;
                r_seq  <= 3'd0;
            end else if (w_fire) begin
                r_pend <= r_pend & ~w_mask;
                // Hold the ordinal on the final index so it never wraps.
                if (!w_single) r_seq <= r_seq + 3'd1;
            end
        end
    end

    assign out_code = w_code;
    assign out_last = out_valid && w_single;
    assign out_seq  = r_seq;
    assign zero_err = r_zero_err;

endmodule
`default_nettype wire

// File: tb/tb_encode8to3_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_encode8to3_stream
// Brief    : Scoreboard bench for encode8to3_stream. Two instances (LSB-first
//            and MSB-first) share stimulus; each has its own expected queue
//            popped by a monitor on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encode8to3_stream;

    typedef struct packed {
        logic [2:0] code;
        logic       last;
        logic [2:0] seq;
    } exp_t;

    logic       clk;
    logic       r_rst_n;
    logic       r_in_valid;
    logic [7:0] r_in_vec;
    logic       r_out_ready;

    logic       w_in_ready1, w_out_valid1, w_out_last1, w_zero_err1;
    logic [2:0] w_out_code1, w_out_seq1;
    logic       w_in_ready0, w_out_valid0, w_out_last0, w_zero_err0;
    logic [2:0] w_out_code0, w_out_seq0;

    exp_t q1[$];
    exp_t q0[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    encode8to3_stream #(.LSB_FIRST(1)) u_dut_lsb (
        .clk       (clk),
        .rst_n     (r_rst_n),
        .in_valid  (r_in_valid),
        .in_ready  (w_in_ready1),
        .in_vec    (r_in_vec),
        .out_valid (w_out_valid1),
        .out_ready (r_out_ready),
        .out_code  (w_out_code1),
        .out_last  (w_out_last1),
        .out_seq   (w_out_seq1),
        .zero_err  (w_zero_err1)
    );

    encode8to3_stream #(.LSB_FIRST(0)) u_dut_msb (
        .clk       (clk),
        .rst_n     (r_rst_n),
        .in_valid  (r_in_valid),
        .in_ready  (w_in_ready0),
        .in_vec    (r_in_vec),
        .out_valid (w_out_valid0),
        .out_ready (r_out_ready),
        .out_code  (w_out_code0),
        .out_last  (w_out_last0),
        .out_seq   (w_out_seq0),
        .zero_err  (w_zero_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // LSB-first monitor: compare head while valid, pop on handshake.
    always @(negedge clk) begin
        if (r_rst_n && w_out_valid1) begin
            chk("lsb_in_ready_low_in_emit", w_in_ready1, 0);
            if (q1.size() == 0) begin
                chk("lsb_unexpected_output", 1, 0);
            end else begin
                chk("lsb_code", w_out_code1, q1[0].code);
                chk("lsb_last", w_out_last1, q1[0].last);
                chk("lsb_seq",  w_out_seq1,  q1[0].seq);
                if (r_out_ready) void'(q1.pop_front());
            end
        end
    end

    // MSB-first monitor.
    always @(negedge clk) begin
        if (r_rst_n && w_out_valid0) begin
            chk("msb_in_ready_low_in_emit", w_in_ready0, 0);
            if (q0.size() == 0) begin
                chk("msb_unexpected_output", 1, 0);
            end else begin
                chk("msb_code", w_out_code0, q0[0].code);
                chk("msb_last", w_out_last0, q0[0].last);
                chk("msb_seq",  w_out_seq0,  q0[0].seq);
                if (r_out_ready) void'(q0.pop_front());
            end
        end
    end

    // codes holds the hand-computed LSB-first index list, entry i at [3*i +: 3].
    task automatic send(input logic [7:0] vec, input int k, input logic [23:0] codes);
        int n = 0;
        r_in_valid = 1'b1;
        r_in_vec   = vec;
        while (!w_in_ready1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("send_timeout", 1, 0);
        for (int i = 0; i < k; i++) begin
            q1.push_back('{code: codes[3*i +: 3], last: 1'(i == k-1), seq: 3'(i)});
            q0.push_back('{code: codes[3*(k-1-i) +: 3], last: 1'(i == k-1), seq: 3'(i)});
        end
        @(posedge clk); #1;
        r_in_valid = 1'b0;
        chk("lsb_valid_after_accept", w_out_valid1, 1);
        chk("msb_valid_after_accept", w_out_valid0, 1);
    endtask

    // Wait for both queues to drain, optionally toggling out_ready each cycle.
    task automatic drain(input bit toggle);
        int n = 0;
        while (q1.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            if (toggle) r_out_ready = ~r_out_ready;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 1, 0);
        r_out_ready = 1'b1;
        chk("lsb_in_ready_after_last", w_in_ready1, 1);
        chk("msb_in_ready_after_last", w_in_ready0, 1);
        chk("lsb_valid_after_last", w_out_valid1, 0);
        chk("msb_queue_empty", q0.size(), 0);
    endtask

    initial begin
        r_rst_n     = 1'b0;
        r_in_valid  = 1'b0;
        r_in_vec    = 8'h00;
        r_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  w_in_ready1,  1);
        chk("rst_out_valid", w_out_valid1, 0);
        chk("rst_out_code",  w_out_code1,  0);
        chk("rst_out_last",  w_out_last1,  0);
        chk("rst_zero_err",  w_zero_err1,  0);
        chk("rst_out_seq",   w_out_seq0,   0);
        r_rst_n = 1'b1;
        @(posedge clk); #1;

        // Multi-hot vector, full-rate drain.
        send(8'b0010_1001, 3, {15'd0, 3'd5, 3'd3, 3'd0});
        drain(1'b0);

        // All bits set with back-pressure every other cycle.
        send(8'hFF, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
        drain(1'b1);

        // Two zero vectors back to back.
        r_in_valid = 1'b1;
        r_in_vec   = 8'h00;
        @(posedge clk); #1;
        chk("zero1_err_lsb", w_zero_err1, 1);
        chk("zero1_err_msb", w_zero_err0, 1);
        chk("zero1_in_ready", w_in_ready1, 1);
        chk("zero1_out_valid", w_out_valid1, 0);
        @(posedge clk); #1;
        r_in_valid = 1'b0;
        chk("zero2_err_lsb", w_zero_err1, 1);
        chk("zero2_in_ready", w_in_ready1, 1);
        chk("zero2_out_valid", w_out_valid0, 0);
        @(posedge clk); #1;
        chk("zero_err_clears", w_zero_err1, 0);

        // Single bit; input changes during EMIT must not matter.
        send(8'h80, 1, {21'd0, 3'd7});
        r_in_vec = 8'hFF;
        drain(1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_after_single", w_out_valid1, 0);
        end

        // Reset in the middle of a vector.
        send(8'hF0, 4, {12'd0, 3'd7, 3'd6, 3'd5, 3'd4});
        begin
            int n = 0;
            while (q1.size() > 2 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 50) chk("midreset_timeout", 1, 0);
        end
        r_rst_n = 1'b0;
        q1.delete();
        q0.delete();
        #1;
        chk("midreset_valid_lsb", w_out_valid1, 0);
        chk("midreset_valid_msb", w_out_valid0, 0);
        @(posedge clk); #1;
        r_rst_n = 1'b1;
        chk("postreset_in_ready", w_in_ready1, 1);
        @(posedge clk); #1;
        chk("postreset_no_output", w_out_valid1, 0);
        send(8'h02, 1, {21'd0, 3'd1});
        drain(1'b0);

        chk("final_q1_empty", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/encode8to3_stream.md
Name: encode8to3_stream

Overview:
- Sequential 8-to-3 encoder. It is the inverse of the team's 3-to-8 decoder.
- Accepts an 8-bit multi-hot vector over a valid/ready handshake and emits one 3-bit index per set bit.
- Indices come out in priority order over a second valid/ready handshake.
- Sits between status/request collectors (interrupt lines, one-hot select buses) and logic that consumes binary indices.

Parameters:
- LSB_FIRST, 1: 1 = indices emitted lowest bit first; 0 = highest bit first.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector
- in_vec  input  8  multi-hot vector to encode
- out_valid  output  1  out_code is valid
- out_ready  input  1  consumer accepts out_code
- out_code  output  3  binary index of the current set bit
- out_last  output  1  out_code is the final index for the current vector
- out_seq  output  3  ordinal of out_code within the current vector (0 = first)
- zero_err  output  1  one-cycle pulse: an all-zero vector was accepted and dropped

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately; pending register = 8'h00; out_seq counter = 0.
  - out_valid = 0, out_last = 0, out_code = 0, zero_err = 0.
  - in_ready = 1, since in_ready is decoded from state IDLE.
- Reset mid-operation: any pending bits are discarded with no further outputs. After rst_n deasserts, the first accepted vector starts fresh at out_seq = 0.
- States:
  - IDLE:
    - in_ready = 1, out_valid = 0.
    - Input accepted when in_valid && in_ready on a rising edge.
    - If in_vec != 0: pending <= in_vec, seq <= 0, go to EMIT.
    - If in_vec == 0: stay in IDLE; zero_err = 1 for the following cycle only.
  - EMIT:
    - in_ready = 0, out_valid = 1.
    - out_code = index of the lowest set bit of pending (LSB_FIRST=1) or highest set bit (LSB_FIRST=0), decoded combinationally from the pending register.
    - out_last = 1 iff pending has exactly one bit set.
    - out_seq = seq.
    - On out_valid && out_ready: clear the emitted bit in pending and increment seq. If out_last was 1, go to IDLE.
- Latency: vector accepted at edge N gives out_valid = 1 in cycle N+1. A vector with k set bits takes exactly k output handshakes. With out_ready held high, the next vector is accepted at the earliest k cycles after N+1.
- Back-pressure: while out_ready = 0, out_code, out_last and out_seq hold stable and out_valid stays 1. out_valid never drops without a handshake, except on reset.
- No overlap: a new vector is not accepted in the same cycle as the last output handshake. in_ready rises in the cycle after the transfer with out_last = 1.
- in_vec is sampled only on the accepting edge. Changes to in_vec while in EMIT are ignored.
- Width rules: out_seq ranges 0..7, reaching 7 only for in_vec = 8'hFF. The seq counter never wraps within a vector.
- zero_err does not affect state. It is a registered, one-cycle pulse per zero vector accepted. Back-to-back zero vectors give consecutive pulses.

Test Plan:
- Reset, then in_vec=8'b0010_1001 with out_ready=1 and LSB_FIRST=1 -> out_code 0,3,5 on three consecutive cycles; out_seq 0,1,2; out_last only on code 5; in_ready returns 1 the cycle after.
- Same vector with LSB_FIRST=0 -> codes 5,3,0 in that order; out_last on code 0.
- in_vec=8'hFF with out_ready toggling 1,0,1,0... -> 8 codes 0..7, each held stable while out_ready=0; out_seq reaches 7 with out_last=1; in_ready stays 0 throughout.
- in_vec=8'h00 accepted twice back-to-back -> zero_err high for two consecutive cycles; out_valid stays 0; in_ready stays 1.
- in_vec=8'h80 (single bit) -> one output, out_code=7, out_seq=0, out_last=1; in_vec changed to 8'hFF during EMIT has no effect.
- rst_n pulsed low after 2 of 4 codes from in_vec=8'hF0 -> out_valid drops immediately; after release in_ready=1; next vector 8'h02 yields out_code=1, out_seq=0, out_last=1.
